intersection_scheduler: RTL and testbench

INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

---
 rtl/semafor_pkg.sv | 45 ++++
 rtl/ped_req_latch.sv | 57 +++++
 rtl/intersection_scheduler.sv | 114 +++++++++++
 tb/tb_intersection_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/semafor_pkg.sv
// Shared phase codes, lamp encodings and timing defaults for the intersection scheduler.
package semafor_pkg;

    typedef enum logic [2:0] {
        PH_G_NS  = 3'd0,
        PH_Y_NS  = 3'd1,
        PH_AR_NS = 3'd2,
        PH_G_EW  = 3'd3,
        PH_Y_EW  = 3'd4,
        PH_AR_EW = 3'd5,
        PH_FLASH = 3'd6,
        PH_BAD   = 3'd7
    } phase_t;

    // Lamp vectors are one-hot {red, yellow, green}.
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

    localparam int GREEN_MIN_DEF = 5;
    localparam int GREEN_MAX_DEF = 20;
    localparam int YELLOW_T_DEF  = 2;
    localparam int ALLRED_T_DEF  = 1;
    localparam int WALK_T_DEF    = 4;

    localparam logic [7:0] TIMER_SAT = 8'hFF;

    // Lamp for one approach in a given phase; blink_off blanks the flashing yellow.
    function automatic logic [2:0] lamp_for(input phase_t ph, input logic is_ew,
                                            input logic blink_off);
        logic [2:0] l;
        l = LAMP_RED;
        case (ph)
            PH_G_NS:  l = is_ew ? LAMP_RED    : LAMP_GREEN;
            PH_Y_NS:  l = is_ew ? LAMP_RED    : LAMP_YELLOW;
            PH_G_EW:  l = is_ew ? LAMP_GREEN  : LAMP_RED;
            PH_Y_EW:  l = is_ew ? LAMP_YELLOW : LAMP_RED;
            PH_FLASH: l = blink_off ? LAMP_OFF : LAMP_YELLOW;
            default:  l = LAMP_RED;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/ped_req_latch.sv
// One approach's pedestrian request latch and walk-lamp timer.
module ped_req_latch
    import semafor_pkg::*;
#(
    parameter int WALK_T = WALK_T_DEF
) (
    input  logic       slow_clk,
    input  logic       rst,
    input  logic       i_req_n,
    input  logic       i_in_green,
    input  logic       i_next_green,
    input  logic [7:0] i_timer_next,
    output logic       o_pend,
    output logic       o_walk
);

    localparam logic [7:0] L_WALK_END = 8'(WALK_T);

    logic r_pend;
    logic r_walk;
    logic w_enter;
    logic w_pend_next;
    logic w_walk_next;

    assign w_enter = i_next_green && !i_in_green;

    always_comb begin
        w_pend_next = r_pend;
        w_walk_next = 1'b0;
        if (w_enter) begin
            // A press in the very cycle of entry is served without ever pending.
            w_pend_next = 1'b0;
            w_walk_next = r_pend | ~i_req_n;
        end else begin
            if (!i_req_n && !i_in_green) begin
                w_pend_next = 1'b1;
            end
            if (i_next_green && r_walk && (i_timer_next != L_WALK_END)) begin
                w_walk_next = 1'b1;
            end
        end
    end

    always_ff @(posedge slow_clk or negedge rst) begin
        if (!rst) begin
            r_pend <= 1'b0;
            r_walk <= 1'b0;
        end else begin
            r_pend <= w_pend_next;
            r_walk <= w_walk_next;
        end
    end

    assign o_pend = r_pend;
    assign o_walk = r_walk;

endmodule

// File: rtl/intersection_scheduler.sv
// Two-way intersection phase sequencer with demand-driven greens, pedestrian walk and maintenance flash.
module intersection_scheduler
    import semafor_pkg::*;
#(
    parameter int GREEN_MIN = GREEN_MIN_DEF,
    parameter int GREEN_MAX = GREEN_MAX_DEF,
    parameter int YELLOW_T  = YELLOW_T_DEF,
    parameter int ALLRED_T  = ALLRED_T_DEF,
    parameter int WALK_T    = WALK_T_DEF
) (
    input  logic       slow_clk,
    input  logic       rst,
    input  logic [1:0] ped_req_n,
    input  logic [1:0] car_sense,
    input  logic       force_flash,
    output logic [2:0] lamp_ns,
    output logic [2:0] lamp_ew,
    output logic [1:0] walk,
    output logic [1:0] ped_pend,
    output logic [2:0] phase,
    output logic [7:0] phase_timer
);

    localparam logic [7:0] L_GMIN_LAST = 8'(GREEN_MIN - 1);
    localparam logic [7:0] L_GMAX_LAST = 8'(GREEN_MAX - 1);
    localparam logic [7:0] L_Y_LAST    = 8'(YELLOW_T - 1);
    localparam logic [7:0] L_AR_LAST   = 8'(ALLRED_T - 1);

    phase_t     r_phase;
    phase_t     w_phase_next;
    logic [7:0] r_timer;
    logic [7:0] w_timer_next;
    logic [2:0] r_lamp_ns;
    logic [2:0] r_lamp_ew;
    logic [1:0] w_demand;
    logic [1:0] w_pend;
    logic [1:0] w_walk;
    logic [1:0] w_in_green;
    logic [1:0] w_next_green;
    logic       w_exit_ns;
    logic       w_exit_ew;

    assign w_demand = car_sense | w_pend;

    // Early exit needs the own approach empty; the max-green cap only needs opposing demand.
    assign w_exit_ns = w_demand[1] &&
                       (((r_timer >= L_GMIN_LAST) && !car_sense[0]) || (r_timer == L_GMAX_LAST));
    assign w_exit_ew = w_demand[0] &&
                       (((r_timer >= L_GMIN_LAST) && !car_sense[1]) || (r_timer == L_GMAX_LAST));

    always_comb begin
        w_phase_next = r_phase;
        case (r_phase)
            PH_G_NS:  if (w_exit_ns) w_phase_next = PH_Y_NS;
            PH_Y_NS:  if (r_timer == L_Y_LAST) w_phase_next = PH_AR_NS;
            PH_AR_NS: if (r_timer == L_AR_LAST) w_phase_next = force_flash ? PH_FLASH : PH_G_EW;
            PH_G_EW:  if (w_exit_ew) w_phase_next = PH_Y_EW;
            PH_Y_EW:  if (r_timer == L_Y_LAST) w_phase_next = PH_AR_EW;
            PH_AR_EW: if (r_timer == L_AR_LAST) w_phase_next = force_flash ? PH_FLASH : PH_G_NS;
            PH_FLASH: if (!force_flash) w_phase_next = PH_AR_EW;
            default:  w_phase_next = PH_AR_EW;
        endcase
    end

    always_comb begin
        w_timer_next = 8'd0;
        if (w_phase_next == r_phase) begin
            w_timer_next = (r_timer == TIMER_SAT) ? r_timer : r_timer + 8'd1;
        end
    end

    assign w_in_green[0]   = (r_phase == PH_G_NS);
    assign w_in_green[1]   = (r_phase == PH_G_EW);
    assign w_next_green[0] = (w_phase_next == PH_G_NS);
    assign w_next_green[1] = (w_phase_next == PH_G_EW);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dir
            ped_req_latch #(.WALK_T(WALK_T)) u_latch (
                .slow_clk     (slow_clk),
                .rst          (rst),
                .i_req_n      (ped_req_n[gi]),
                .i_in_green   (w_in_green[gi]),
                .i_next_green (w_next_green[gi]),
                .i_timer_next (w_timer_next),
                .o_pend       (w_pend[gi]),
                .o_walk       (w_walk[gi])
            );
        end
    endgenerate

    always_ff @(posedge slow_clk or negedge rst) begin
        if (!rst) begin
            r_phase   <= PH_G_NS;
            r_timer   <= 8'd0;
            r_lamp_ns <= LAMP_GREEN;
            r_lamp_ew <= LAMP_RED;
        end else begin
            r_phase   <= w_phase_next;
            r_timer   <= w_timer_next;
            // Lamps are registered from next-state so they line up with phase and timer.
            r_lamp_ns <= lamp_for(w_phase_next, 1'b0, w_timer_next[0]);
            r_lamp_ew <= lamp_for(w_phase_next, 1'b1, w_timer_next[0]);
        end
    end

    assign lamp_ns     = r_lamp_ns;
    assign lamp_ew     = r_lamp_ew;
    assign walk        = w_walk;
    assign ped_pend    = w_pend;
    assign phase       = r_phase;
    assign phase_timer = r_timer;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Scoreboard bench: expected phase runs are queued with the stimulus and checked as the DUT walks through them.
module tb_intersection_scheduler;

    logic       slow_clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] ped_req_n = 2'b11;
    logic [1:0] car_sense = 2'b00;
    logic       force_flash = 1'b0;
    logic [2:0] lamp_ns;
    logic [2:0] lamp_ew;
    logic [1:0] walk;
    logic [1:0] ped_pend;
    logic [2:0] phase;
    logic [7:0] phase_timer;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int ph;
        int len;
    } run_t;
    run_t sb_q[$];

    intersection_scheduler dut (
        .slow_clk    (slow_clk),
        .rst         (rst),
        .ped_req_n   (ped_req_n),
        .car_sense   (car_sense),
        .force_flash (force_flash),
        .lamp_ns     (lamp_ns),
        .lamp_ew     (lamp_ew),
        .walk        (walk),
        .ped_pend    (ped_pend),
        .phase       (phase),
        .phase_timer (phase_timer)
    );

    always #5 slow_clk = ~slow_clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge slow_clk);
        #1;
    endtask

    task automatic sb_push(input int ph, input int len);
        run_t e;
        e.ph  = ph;
        e.len = len;
        sb_q.push_back(e);
    endtask

    // Counts the cycles of the phase currently shown; returns on the first cycle of the next one.
    task automatic measure_run(output int ph, output int len);
        ph  = int'(phase);
        len = 1;
        for (int k = 0; k < 300; k++) begin
            cyc();
            if (int'(phase) != ph) return;
            len++;
        end
    endtask

    task automatic sb_drain();
        run_t e;
        int   ph;
        int   len;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            measure_run(ph, len);
            $display("[TB] run phase=%0d len=%0d (want phase=%0d len=%0d)", ph, len, e.ph, e.len);
            check_eq("sb_phase", ph, e.ph);
            check_eq("sb_len", len, e.len);
        end
    endtask

    task automatic wait_phase(input string tag, input int p);
        for (int k = 0; k < 100; k++) begin
            if (int'(phase) == p) break;
            cyc();
        end
        check_eq(tag, int'(phase), p);
    endtask

    task automatic reset_into(input logic [1:0] cs);
        cyc();
        rst = 1'b0;
        car_sense = cs;
        ped_req_n = 2'b11;
        force_flash = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    task automatic count_walk(input string tag, input int dir, input int exp);
        int cnt;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (!walk[dir]) break;
            cnt++;
            cyc();
        end
        check_eq(tag, cnt, exp);
    endtask

    // Continuous safety watch: no conflicting non-red lamps and no walk outside its green.
    always @(negedge slow_clk) begin
        if (rst && phase != 3'd6) begin
            check_eq("excl_green_yellow", int'((|lamp_ns[1:0]) && (|lamp_ew[1:0])), 0);
            check_eq("walk_ns_outside_g", int'(walk[0] && phase != 3'd0), 0);
            check_eq("walk_ew_outside_g", int'(walk[1] && phase != 3'd3), 0);
        end
    end

    initial begin
        // Reset values, with buttons held during reset
        cyc();
        ped_req_n = 2'b00;
        car_sense = 2'b10;
        cyc();
        cyc();
        check_eq("rst_phase", phase, 0);
        check_eq("rst_timer", phase_timer, 0);
        check_eq("rst_lamp_ns", lamp_ns, 3'b001);
        check_eq("rst_lamp_ew", lamp_ew, 3'b100);
        check_eq("rst_walk", walk, 0);
        check_eq("rst_pend", ped_pend, 0);

        // Min-green exit with EW cars only
        reset_into(2'b10);
        sb_push(0, 5); sb_push(1, 2); sb_push(2, 1);
        sb_drain();
        check_eq("s1_g_ew", phase, 3);
        check_eq("s1_lamp_ew", lamp_ew, 3'b001);
        check_eq("s1_lamp_ns", lamp_ns, 3'b100);
        for (int k = 0; k < 260; k++) cyc();
        check_eq("rest_phase", phase, 3);
        check_eq("rest_timer_sat", phase_timer, 255);

        // Max-green cap with both approaches busy
        reset_into(2'b11);
        sb_push(0, 20); sb_push(1, 2); sb_push(2, 1);
        sb_drain();
        check_eq("s2_g_ew", phase, 3);

        // EW pedestrian press during G_NS
        reset_into(2'b00);
        cyc();
        cyc();
        ped_req_n = 2'b01;
        cyc();
        ped_req_n = 2'b11;
        for (int k = 0; k < 40; k++) begin
            if (phase == 3'd3) break;
            check_eq("s3_pend_held", ped_pend, 2'b10);
            cyc();
        end
        check_eq("s3_g_ew", phase, 3);
        check_eq("s3_walk_entry", walk, 2'b10);
        check_eq("s3_pend_clr", ped_pend, 0);
        count_walk("s3_walk_len", 1, 4);
        check_eq("s3_pend_after", ped_pend, 0);

        // NS press in the cycle of AR_EW -> G_NS
        car_sense = 2'b01;
        wait_phase("s4_ar_ew", 5);
        ped_req_n = 2'b10;
        cyc();
        ped_req_n = 2'b11;
        check_eq("s4_g_ns", phase, 0);
        check_eq("s4_walk_entry", walk, 2'b01);
        check_eq("s4_pend", ped_pend, 0);
        count_walk("s4_walk_len", 0, 4);
        check_eq("s4_pend_after", ped_pend, 0);

        // Maintenance flash requested during G_EW
        car_sense = 2'b10;
        wait_phase("s5_g_ew", 3);
        force_flash = 1'b1;
        car_sense = 2'b01;
        sb_push(3, 5); sb_push(4, 2); sb_push(5, 1);
        sb_drain();
        check_eq("s5_flash", phase, 6);
        for (int k = 0; k < 6; k++) begin
            check_eq("s5_flash_timer", phase_timer, k);
            check_eq("s5_flash_ns", lamp_ns, (k % 2 == 0) ? 3'b010 : 3'b000);
            check_eq("s5_flash_ew", lamp_ew, (k % 2 == 0) ? 3'b010 : 3'b000);
            check_eq("s5_flash_walk", walk, 0);
            cyc();
        end
        force_flash = 1'b0;
        cyc();
        check_eq("s5_exit_ar_ew", phase, 5);
        check_eq("s5_exit_ns_red", lamp_ns, 3'b100);
        check_eq("s5_exit_ew_red", lamp_ew, 3'b100);
        cyc();
        check_eq("s5_then_g_ns", phase, 0);

        // Reset during Y_EW with an NS request pending
        car_sense = 2'b10;
        wait_phase("s6_g_ew", 3);
        car_sense = 2'b00;
        ped_req_n = 2'b10;
        cyc();
        ped_req_n = 2'b11;
        check_eq("s6_pend_set", ped_pend, 2'b01);
        wait_phase("s6_y_ew", 4);
        check_eq("s6_pend_in_y", ped_pend, 2'b01);
        rst = 1'b0;
        #1;
        check_eq("s6_rst_phase", phase, 0);
        check_eq("s6_rst_timer", phase_timer, 0);
        check_eq("s6_rst_pend", ped_pend, 0);
        check_eq("s6_rst_walk", walk, 0);
        check_eq("s6_rst_lamp_ns", lamp_ns, 3'b001);
        cyc();
        rst = 1'b1;
        cyc();
        check_eq("s6_resume_phase", phase, 0);
        check_eq("s6_resume_timer", phase_timer, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
